// File: rtl/dircc_types_pkg.sv
// Shared DiRCC types.
//   device_state_t           : per-device state record held in on-chip memory
//   dircc_send_sched_state_t : send scheduler FSM encoding
//   DIRCC_PACKET_WIDTH_DEFAULT : default network packet width
package dircc_types_pkg;

  localparam int DIRCC_PACKET_WIDTH_DEFAULT = 96;

  // rts (ready-to-send) is the MSB so a cleared record reads as "nothing to send".
  typedef struct packed {
    logic        rts;
    logic [30:0] aux;
    logic [31:0] count;
  } device_state_t;

  typedef enum logic [2:0] {
    SS_IDLE    = 3'd0,
    SS_RD_REQ  = 3'd1,
    SS_RD_WAIT = 3'd2,
    SS_PRESENT = 3'd3,
    SS_SAMPLE  = 3'd4,
    SS_SEND    = 3'd5,
    SS_WR      = 3'd6,
    SS_NEXT    = 3'd7
  } dircc_send_sched_state_t;

endpackage

// File: rtl/dircc_device_index_gen.sv
// Round-robin device index generator for the send scheduler.
// Ports:
//   clk, reset_n : clock, async active-low reset (index returns to 0)
//   advance      : step to the next device this cycle
//   address      : STATE_BASE_ADDR + index*STATE_STRIDE, truncated
//   sweep_done   : high while advancing from the last device back to 0
module dircc_device_index_gen #(
  parameter int MEM_ADDRESS_WIDTH = 32,
  parameter int NUM_DEVICES       = 16,
  parameter int STATE_BASE_ADDR   = 0,
  parameter int STATE_STRIDE      = 16,
  parameter int IDX_W             = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         advance,
  output logic [MEM_ADDRESS_WIDTH-1:0] address,
  output logic                         sweep_done
);

  logic [IDX_W-1:0] index;
  logic             last;

  assign last       = (index == IDX_W'(NUM_DEVICES - 1));
  assign sweep_done = advance && last;

  // Arithmetic is done at the address width so the result wraps naturally.
  assign address = MEM_ADDRESS_WIDTH'(STATE_BASE_ADDR)
                 + MEM_ADDRESS_WIDTH'(index) * MEM_ADDRESS_WIDTH'(STATE_STRIDE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index <= '0;
    end else if (advance) begin
      index <= last ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/dircc_send_scheduler.sv
// DiRCC per-device send scheduler.
// Scans device states round-robin: reads a state from memory, presents it to
// the send handler, and when the handler raises a packet forwards it to the
// network (valid/ready) and writes the updated state back.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   enable                 : scanning permitted (sampled in IDLE and NEXT)
//   mem_*                  : Avalon-MM style state memory master
//   handler_*              : send handler interface (registered, 1-cycle)
//   packet_out*            : outbound packet, valid/ready
//   busy, sweep_done       : status
// Optional build macro DIRCC_SEND_SCHED_STATS_EN adds sent_count and
// sweep_count (32-bit wrapping counters).
module dircc_send_scheduler
  import dircc_types_pkg::*;
#(
  parameter int MEM_ADDRESS_WIDTH = 32,
  parameter int NUM_DEVICES       = 16,
  parameter int STATE_BASE_ADDR   = 0,
  parameter int STATE_STRIDE      = 16,
  parameter int PACKET_WIDTH      = DIRCC_PACKET_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  output logic [MEM_ADDRESS_WIDTH-1:0] mem_address,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [$bits(device_state_t)-1:0] mem_writedata,
  input  logic [$bits(device_state_t)-1:0] mem_readdata,
  input  logic                         mem_readdatavalid,
  input  logic                         mem_waitrequest,
  output logic [MEM_ADDRESS_WIDTH-1:0] handler_address,
  output device_state_t                handler_read_state,
  input  logic [PACKET_WIDTH-1:0]      handler_packet,
  input  logic                         handler_packet_valid,
  input  device_state_t                handler_write_state,
  input  logic                         handler_write_state_valid,
  output logic [PACKET_WIDTH-1:0]      packet_out,
  output logic                         packet_out_valid,
  input  logic                         packet_out_ready,
  output logic                         busy,
  output logic                         sweep_done
`ifdef DIRCC_SEND_SCHED_STATS_EN
  ,
  output logic [31:0]                  sent_count,
  output logic [31:0]                  sweep_count
`endif
);

  dircc_send_sched_state_t fsm;
  device_state_t           state_reg;
  logic [MEM_ADDRESS_WIDTH-1:0] dev_address;

  // packet_valid is authoritative; the handler's state-valid flag is not needed.
  logic unused_state_valid;
  assign unused_state_valid = handler_write_state_valid;

  dircc_device_index_gen #(
    .MEM_ADDRESS_WIDTH (MEM_ADDRESS_WIDTH),
    .NUM_DEVICES       (NUM_DEVICES),
    .STATE_BASE_ADDR   (STATE_BASE_ADDR),
    .STATE_STRIDE      (STATE_STRIDE)
  ) u_index_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (fsm == SS_NEXT),
    .address    (dev_address),
    .sweep_done (sweep_done)
  );

  assign mem_read         = (fsm == SS_RD_REQ);
  assign mem_write        = (fsm == SS_WR);
  assign mem_address      = (mem_read || mem_write) ? dev_address : '0;
  assign handler_address  = dev_address;
  assign packet_out_valid = (fsm == SS_SEND);
  assign busy             = (fsm != SS_IDLE);

  // Present the state only in PRESENT/SAMPLE so the handler's registered
  // valids are guaranteed low on entry to PRESENT.
  assign handler_read_state = (fsm == SS_PRESENT || fsm == SS_SAMPLE) ? state_reg : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm           <= SS_IDLE;
      packet_out    <= '0;
      mem_writedata <= '0;
    end else begin
      case (fsm)
        SS_IDLE:    if (enable) fsm <= SS_RD_REQ;
        SS_RD_REQ:  if (!mem_waitrequest) fsm <= SS_RD_WAIT;
        SS_RD_WAIT: if (mem_readdatavalid) fsm <= SS_PRESENT;
        SS_PRESENT: fsm <= SS_SAMPLE;
        SS_SAMPLE: begin
          if (handler_packet_valid) begin
            packet_out    <= handler_packet;
            mem_writedata <= handler_write_state;
            fsm           <= SS_SEND;
          end else begin
            fsm <= SS_NEXT;
          end
        end
        SS_SEND:    if (packet_out_ready) fsm <= SS_WR;
        SS_WR:      if (!mem_waitrequest) fsm <= SS_NEXT;
        SS_NEXT:    fsm <= enable ? SS_RD_REQ : SS_IDLE;
        default:    fsm <= SS_IDLE;
      endcase
    end
  end

  // Captured state is only observed after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fsm == SS_RD_WAIT && mem_readdatavalid) begin
      state_reg <= mem_readdata;
    end
  end

`ifdef DIRCC_SEND_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_count  <= '0;
      sweep_count <= '0;
    end else begin
      if (packet_out_valid && packet_out_ready) sent_count <= sent_count + 32'd1;
      if (sweep_done) sweep_count <= sweep_count + 32'd1;
    end
  end
`endif

endmodule
